lbuf_dp_ctrl: RTL and testbench

Parametrised dual-port local buffer for pixel/feature data: a behavioural DEPTH x (LANES*LANE_W) array with two independent read/write ports and per-lane active-low write enables.
- Deterministic same-address collision resolution: per-lane port-A priority plus write-first forwarding.
- Registered reads with valid strobes.
- Hardware clear engine that zeroes the array.
- Saturating collision counter for performance debug.
Sits between the layer controller and the PE array as the drop-in successor of the fixed-size pixel SRAM wrapper.

---
 rtl/lbuf_dp_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lbuf_dp_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbuf_dp_ctrl.sv
// Dual-port, lane-writable local buffer: port-A priority on shared lanes, write-first
// forwarding to a colliding reader, registered reads, sequential clear engine, collision counter.
module lbuf_dp_ctrl #(
    parameter int LANES  = 3,
    parameter int LANE_W = 16,
    parameter int DEPTH  = 1024,
    parameter int CNT_W  = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int DATA_W = LANES * LANE_W
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              clr_start,
    output logic              busy,
    input  logic              a_oe,
    input  logic [LANES-1:0]  a_wen,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_dvalid,
    input  logic              b_oe,
    input  logic [LANES-1:0]  b_wen,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_dvalid,
    output logic [CNT_W-1:0]  coll_cnt
);

    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;
    typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE} op_t;

    state_t r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_dout, r_b_dout;
    logic              r_a_dvalid, r_b_dvalid;
    logic [CNT_W-1:0]  r_coll_cnt;

    logic              w_clr_we, w_cnt_clr, w_port_en;
    logic              w_a_inr, w_b_inr, w_same, w_coll_wr;
    op_t               w_a_op, w_b_op;
    logic [DATA_W-1:0] w_a_rdata, w_b_rdata;

    assign w_a_inr = ({1'b0, a_addr} < L_DEPTH);
    assign w_b_inr = ({1'b0, b_addr} < L_DEPTH);

    // Clear FSM: state register and next-state/control decode.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_port_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_port_en = 1'b1;
                end
            end
            S_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_ptr == L_LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_op = OP_IDLE;
        w_b_op = OP_IDLE;
        if (w_port_en) begin
            if (!(&a_wen))  w_a_op = OP_WRITE;
            else if (a_oe)  w_a_op = OP_READ;
            if (!(&b_wen))  w_b_op = OP_WRITE;
            else if (b_oe)  w_b_op = OP_READ;
        end
    end

    assign w_same    = w_a_inr && w_b_inr && (a_addr == b_addr)
                       && (w_a_op != OP_IDLE) && (w_b_op != OP_IDLE);
    assign w_coll_wr = w_same && ((w_a_op == OP_WRITE) || (w_b_op == OP_WRITE));

    // Write-first: a reader colliding with a writer sees the writer's lanes this cycle.
    always_comb begin
        w_a_rdata = '0;
        w_b_rdata = '0;
        if (w_a_inr) w_a_rdata = r_mem[a_addr];
        if (w_b_inr) w_b_rdata = r_mem[b_addr];
        for (int i = 0; i < LANES; i++) begin
            if (w_same && (w_b_op == OP_WRITE) && !b_wen[i])
                w_a_rdata[i*LANE_W +: LANE_W] = b_din[i*LANE_W +: LANE_W];
            if (w_same && (w_a_op == OP_WRITE) && !a_wen[i])
                w_b_rdata[i*LANE_W +: LANE_W] = a_din[i*LANE_W +: LANE_W];
        end
    end

    // NOTE: the storage array has no reset; it is zeroed only by the clear engine.
    always_ff @(posedge CK) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end
        // Port A is assigned after port B so it owns any lane both ports write.
        for (int i = 0; i < LANES; i++) begin
            if ((w_b_op == OP_WRITE) && w_b_inr && !b_wen[i])
                r_mem[b_addr][i*LANE_W +: LANE_W] <= b_din[i*LANE_W +: LANE_W];
            if ((w_a_op == OP_WRITE) && w_a_inr && !a_wen[i])
                r_mem[a_addr][i*LANE_W +: LANE_W] <= a_din[i*LANE_W +: LANE_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_a_dout   <= '0;
            r_b_dout   <= '0;
            r_a_dvalid <= 1'b0;
            r_b_dvalid <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_CLEAR);
            if (w_cnt_clr)     r_ptr <= '0;
            else if (w_clr_we) r_ptr <= r_ptr + ADDR_W'(1);

            r_a_dvalid <= (w_a_op == OP_READ);
            r_b_dvalid <= (w_b_op == OP_READ);
            if (w_a_op == OP_READ) r_a_dout <= w_a_rdata;
            if (w_b_op == OP_READ) r_b_dout <= w_b_rdata;

            if (w_cnt_clr)
                r_coll_cnt <= '0;
            else if (w_coll_wr && (r_coll_cnt != {CNT_W{1'b1}}))
                r_coll_cnt <= r_coll_cnt + CNT_W'(1);
        end
    end

    assign busy     = r_busy;
    assign a_dout   = r_a_dout;
    assign b_dout   = r_b_dout;
    assign a_dvalid = r_a_dvalid;
    assign b_dvalid = r_b_dvalid;
    assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_lbuf_dp_ctrl.sv
// Bench for lbuf_dp_ctrl: directed scenarios plus randomized traffic checked against
// a word-array reference model that applies writes and then returns post-write contents.
module tb_lbuf_dp_ctrl;

    localparam int LANES  = 3;
    localparam int LANE_W = 16;
    localparam int DEPTH  = 24;
    localparam int CNT_W  = 3;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = LANES * LANE_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CK = 1'b0;
    logic              RST = 1'b1;
    logic              clr_start = 1'b0;
    logic              busy;
    logic              a_oe = 1'b0, b_oe = 1'b0;
    logic [LANES-1:0]  a_wen = '1, b_wen = '1;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_din = '0, b_din = '0;
    logic [DATA_W-1:0] a_dout, b_dout;
    logic              a_dvalid, b_dvalid;
    logic [CNT_W-1:0]  coll_cnt;

    lbuf_dp_ctrl #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CK(CK), .RST(RST), .clr_start(clr_start), .busy(busy),
        .a_oe(a_oe), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout), .a_dvalid(a_dvalid),
        .b_oe(b_oe), .b_wen(b_wen), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout), .b_dvalid(b_dvalid),
        .coll_cnt(coll_cnt)
    );

    always #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cnt, m_left;
    logic [DATA_W-1:0] m_a_dout, m_b_dout;
    logic              m_a_dv, m_b_dv;

    task automatic model_reset();
        m_cnt = 0; m_left = 0;
        m_a_dout = '0; m_b_dout = '0;
        m_a_dv = 1'b0; m_b_dv = 1'b0;
    endtask

    // Predicts the registered outputs after the coming edge from the inputs now applied.
    task automatic model_edge();
        bit aw, ar, bw, br, ai, bi;
        m_a_dv = 1'b0;
        m_b_dv = 1'b0;
        if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
            return;
        end
        if (clr_start) begin
            m_left = DEPTH;
            m_cnt  = 0;
            return;
        end
        aw = (a_wen != '1); ar = !aw && a_oe; ai = (int'(a_addr) < DEPTH);
        bw = (b_wen != '1); br = !bw && b_oe; bi = (int'(b_addr) < DEPTH);
        // B first, then A, so A owns any lane both ports write.
        for (int l = 0; l < LANES; l++)
            if (bw && bi && !b_wen[l]) m_mem[b_addr][l*LANE_W +: LANE_W] = b_din[l*LANE_W +: LANE_W];
        for (int l = 0; l < LANES; l++)
            if (aw && ai && !a_wen[l]) m_mem[a_addr][l*LANE_W +: LANE_W] = a_din[l*LANE_W +: LANE_W];
        if (ar) begin m_a_dv = 1'b1; m_a_dout = ai ? m_mem[a_addr] : '0; end
        if (br) begin m_b_dv = 1'b1; m_b_dout = bi ? m_mem[b_addr] : '0; end
        if (ai && bi && (a_addr == b_addr) && (aw || ar) && (bw || br) && (aw || bw)
            && (m_cnt < CNT_MAX))
            m_cnt++;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CK);
        #1;
    endtask

    task automatic idle_ports();
        clr_start = 1'b0;
        a_oe = 1'b0; a_wen = '1; a_addr = '0; a_din = '0;
        b_oe = 1'b0; b_wen = '1; b_addr = '0; b_din = '0;
    endtask

    task automatic wait_clear_done(output int n_busy);
        n_busy = 0;
        idle_ports();
        for (int g = 0; g < DEPTH + 8; g++) begin
            if (busy !== 1'b1) break;
            n_busy++;
            cycle();
        end
    endtask

    task automatic test_reset();
        idle_ports();
        repeat (3) @(posedge CK);
        #1;
        n_tests++;
        if ({busy, a_dvalid, b_dvalid} !== 3'b000 || a_dout !== '0 || b_dout !== '0 || coll_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b a_dv=%b b_dv=%b a_dout=%h b_dout=%h cnt=%0d, expected all 0",
                     busy, a_dvalid, b_dvalid, a_dout, b_dout, coll_cnt);
        end
        RST = 1'b0;
        model_reset();
        @(posedge CK); #1;
    endtask

    task automatic test_clear();
        int n_busy, bad_dv;
        idle_ports();
        clr_start = 1'b1; a_oe = 1'b1; a_addr = 5'd3;
        cycle();
        n_tests++;
        if (busy !== 1'b1 || a_dvalid !== 1'b0 || coll_cnt !== '0) begin
            n_fail++;
            $display("FAIL clear_start: busy=%b a_dv=%b cnt=%0d, expected busy=1 a_dv=0 cnt=0", busy, a_dvalid, coll_cnt);
        end
        n_busy = 1; bad_dv = 0;
        for (int g = 0; g < DEPTH + 8; g++) begin
            idle_ports();
            a_oe = 1'b1; a_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            b_wen = '0; b_addr = '0; b_din = 48'hFFFF_FFFF_FFFF;
            clr_start = (g == 4);
            cycle();
            if (a_dvalid !== 1'b0 || b_dvalid !== 1'b0) bad_dv++;
            if (busy !== 1'b1) break;
            n_busy++;
        end
        n_tests++;
        if (n_busy != DEPTH) begin
            n_fail++;
            $display("FAIL clear_busy_len: busy cycles=%0d, expected %0d", n_busy, DEPTH);
        end
        n_tests++;
        if (bad_dv != 0) begin
            n_fail++;
            $display("FAIL clear_no_dvalid: %0d cycles with dvalid during busy, expected 0", bad_dv);
        end
        idle_ports();
        a_oe = 1'b1; a_addr = '0;
        cycle();
        n_tests++;
        if (a_dvalid !== 1'b1 || a_dout !== '0) begin
            n_fail++;
            $display("FAIL clear_first_idle_read: a_dv=%b a_dout=%h, expected 1 / 0", a_dvalid, a_dout);
        end
        for (int ad = 0; ad < DEPTH; ad++) begin
            idle_ports();
            a_oe = 1'b1; a_addr = ADDR_W'(ad);
            b_oe = 1'b1; b_addr = ADDR_W'(DEPTH - 1 - ad);
            cycle();
            n_tests++;
            if (a_dvalid !== 1'b1 || b_dvalid !== 1'b1 || a_dout !== '0 || b_dout !== '0) begin
                n_fail++;
                $display("FAIL clear_readback addr %0d: a=%b/%h b=%b/%h, expected 1/0 1/0",
                         ad, a_dvalid, a_dout, b_dvalid, b_dout);
            end
        end
    endtask

    task automatic test_write_read();
        idle_ports();
        a_wen = 3'b000; a_oe = 1'b1; a_addr = 5'd5; a_din = 48'h0001_0002_0003;
        cycle();
        n_tests++;
        if (a_dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_dvalid: a_dv=%b, expected 0", a_dvalid);
        end
        idle_ports();
        b_oe = 1'b1; b_addr = 5'd5;
        cycle();
        n_tests++;
        if (b_dvalid !== 1'b1 || b_dout !== 48'h0001_0002_0003) begin
            n_fail++;
            $display("FAIL write_read: b_dv=%b b_dout=%h, expected 1 / 000100020003", b_dvalid, b_dout);
        end
        idle_ports();
        cycle();
        n_tests++;
        if (b_dvalid !== 1'b0 || b_dout !== 48'h0001_0002_0003) begin
            n_fail++;
            $display("FAIL dout_hold: b_dv=%b b_dout=%h, expected 0 / 000100020003", b_dvalid, b_dout);
        end
    endtask

    task automatic test_both_write();
        idle_ports();
        a_wen = 3'b000; a_addr = 5'd9; a_din = 48'h1234_5678_9ABC;
        cycle();
        idle_ports();
        a_wen = 3'b110; a_addr = 5'd9; a_din = 48'h0000_0000_AAAA;
        b_wen = 3'b100; b_addr = 5'd9; b_din = 48'h0000_BBBB_BBBB;
        cycle();
        n_tests++;
        if (coll_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL both_write_cnt: cnt=%0d, expected 1", coll_cnt);
        end
        idle_ports();
        a_oe = 1'b1; a_addr = 5'd9;
        cycle();
        n_tests++;
        if (a_dvalid !== 1'b1 || a_dout !== 48'h1234_BBBB_AAAA) begin
            n_fail++;
            $display("FAIL both_write_data: a_dv=%b a_dout=%h, expected 1 / 1234bbbbaaaa", a_dvalid, a_dout);
        end
    endtask

    task automatic test_read_write_coll();
        idle_ports();
        b_wen = 3'b000; b_addr = 5'd20; b_din = 48'h1111_2222_3333;
        cycle();
        idle_ports();
        a_oe = 1'b1; a_addr = 5'd20;
        b_wen = 3'b011; b_addr = 5'd20; b_din = 48'h7777_DEAD_BEEF;
        cycle();
        n_tests++;
        if (a_dvalid !== 1'b1 || a_dout !== 48'h7777_2222_3333 || b_dvalid !== 1'b0 || coll_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL read_write_coll: a=%b/%h b_dv=%b cnt=%0d, expected 1/777722223333 0 2",
                     a_dvalid, a_dout, b_dvalid, coll_cnt);
        end
        idle_ports();
        a_oe = 1'b1; a_addr = 5'd20;
        b_oe = 1'b1; b_addr = 5'd20;
        cycle();
        n_tests++;
        if (a_dout !== 48'h7777_2222_3333 || b_dout !== 48'h7777_2222_3333 || coll_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL both_read: a=%h b=%h cnt=%0d, expected 777722223333 twice, cnt 2", a_dout, b_dout, coll_cnt);
        end
    endtask

    task automatic test_out_of_range();
        idle_ports();
        a_wen = 3'b000; a_addr = 5'd26; a_din = 48'hDEAD_DEAD_DEAD;
        b_wen = 3'b000; b_addr = 5'd26; b_din = 48'hBEEF_BEEF_BEEF;
        cycle();
        n_tests++;
        if (coll_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL oor_no_count: cnt=%0d, expected 2", coll_cnt);
        end
        idle_ports();
        a_oe = 1'b1; a_addr = 5'd26;
        b_oe = 1'b1; b_addr = 5'd2;
        cycle();
        n_tests++;
        if (a_dvalid !== 1'b1 || a_dout !== '0 || b_dvalid !== 1'b1 || b_dout !== '0 || coll_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL oor_read: a=%b/%h b=%b/%h cnt=%0d, expected 1/0 1/0 2",
                     a_dvalid, a_dout, b_dvalid, b_dout, coll_cnt);
        end
    endtask

    task automatic test_saturation();
        int n_busy;
        for (int k = 0; k < 9; k++) begin
            idle_ports();
            a_wen = 3'b000; a_addr = 5'd1; a_din = DATA_W'(k);
            b_wen = 3'b010; b_addr = 5'd1; b_din = DATA_W'(k + 100);
            cycle();
            n_tests++;
            if (coll_cnt !== CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL sat_step %0d: cnt=%0d, expected %0d", k, coll_cnt, m_cnt);
            end
        end
        n_tests++;
        if (coll_cnt !== 3'd7) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d, expected 7", coll_cnt);
        end
        idle_ports();
        clr_start = 1'b1;
        cycle();
        n_tests++;
        if (coll_cnt !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_resets_cnt: cnt=%0d busy=%b, expected 0 / 1", coll_cnt, busy);
        end
        wait_clear_done(n_busy);
        n_tests++;
        if (n_busy != DEPTH) begin
            n_fail++;
            $display("FAIL sat_clear_len: busy cycles=%0d, expected %0d", n_busy, DEPTH);
        end
    endtask

    task automatic rand_port(output logic oe, output logic [LANES-1:0] wen,
                             output logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] din);
        oe   = 1'($urandom_range(0, 1));
        wen  = ($urandom_range(0, 9) < 4) ? LANES'($urandom) : '1;
        addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 3));
        din  = DATA_W'({$urandom, $urandom});
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle_ports();
            rand_port(a_oe, a_wen, a_addr, a_din);
            rand_port(b_oe, b_wen, b_addr, b_din);
            cycle();
            n_tests++;
            if (a_dvalid !== m_a_dv || a_dout !== m_a_dout || b_dvalid !== m_b_dv
                || b_dout !== m_b_dout || coll_cnt !== CNT_W'(m_cnt) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL random cyc %0d: a=%b/%h b=%b/%h cnt=%0d busy=%b, expected a=%b/%h b=%b/%h cnt=%0d busy=0",
                         c, a_dvalid, a_dout, b_dvalid, b_dout, coll_cnt, busy,
                         m_a_dv, m_a_dout, m_b_dv, m_b_dout, m_cnt);
            end
        end
    endtask

    task automatic test_reset_during_clear();
        int n_busy;
        idle_ports();
        a_wen = 3'b000; a_addr = 5'd4; a_din = 48'hCAFE_F00D_1234;
        cycle();
        idle_ports();
        a_oe = 1'b1; a_addr = 5'd4; b_oe = 1'b1; b_addr = 5'd4;
        cycle();
        idle_ports();
        clr_start = 1'b1;
        cycle();
        idle_ports();
        repeat (3) cycle();
        #2 RST = 1'b1;
        #1;
        n_tests++;
        if ({busy, a_dvalid, b_dvalid} !== 3'b000 || a_dout !== '0 || b_dout !== '0 || coll_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset_in_clear: busy=%b a=%b/%h b=%b/%h cnt=%0d, expected all 0",
                     busy, a_dvalid, a_dout, b_dvalid, b_dout, coll_cnt);
        end
        model_reset();
        @(posedge CK);
        #1 RST = 1'b0;
        clr_start = 1'b1;
        cycle();
        wait_clear_done(n_busy);
        n_tests++;
        if (n_busy != DEPTH) begin
            n_fail++;
            $display("FAIL reclear_len: busy cycles=%0d, expected %0d", n_busy, DEPTH);
        end
        for (int ad = 0; ad < DEPTH; ad++) begin
            idle_ports();
            a_oe = 1'b1; a_addr = ADDR_W'(ad);
            cycle();
            n_tests++;
            if (a_dvalid !== 1'b1 || a_dout !== '0) begin
                n_fail++;
                $display("FAIL reclear_readback addr %0d: a=%b/%h, expected 1/0", ad, a_dvalid, a_dout);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_clear();
        test_write_read();
        test_both_write();
        test_read_write_coll();
        test_out_of_range();
        test_saturation();
        test_random();
        test_reset_during_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
